// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential multiplier.
//   MUL_WIDTH : default operand width
//   state_e   : controller states (encodings match the legacy header values)
package mult16_seq_pkg;

    localparam int MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult16_seq_adder16.sv
// Ripple-carry adder used by the multiplier to fold in one partial product
// per cycle. Purely combinational.
//   adder1bit : full-adder cell
//     A, B, C_in -> S, C_out
//   adder16   : WIDTH-bit chain of adder1bit cells
//     A, B  [WIDTH-1:0] operands
//     C_in              carry in
//     S     [WIDTH-1:0] sum
//     C_out             carry out of the top bit
module adder1bit (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);
    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module adder16
    import mult16_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);
    logic [WIDTH:0] carry;

    assign carry[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        adder1bit u_bit (
            .A     (A[i]),
            .B     (B[i]),
            .C_in  (carry[i]),
            .S     (S[i]),
            .C_out (carry[i+1])
        );
    end

    assign C_out = carry[WIDTH];
endmodule

// File: rtl/mult16_seq.sv
// Sequential unsigned shift-and-add multiplier (multi-cycle MUL unit).
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request a multiply, accepted when not busy (also in DONE)
//   a, b     : multiplicand / multiplier, captured on accepted start
//   busy     : high while iterating
//   done     : one-cycle pulse, product valid
//   product  : 2*WIDTH-bit result, held until the next accepted start
module mult16_seq
    import mult16_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             sum_carry;

    // Partial product is the multiplicand gated by the current multiplier LSB.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    adder16 #(.WIDTH(WIDTH)) u_adder (
        .A     (acc_hi_q),
        .B     (addend),
        .C_in  (1'b0),
        .S     (sum),
        .C_out (sum_carry)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // {carry, sum} shifted right by one across the accumulator;
                // the carry lands in the top bit, so nothing overflows.
                acc_hi_d = {sum_carry, sum[WIDTH-1:1]};
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = {acc_hi_q, acc_lo_q};
endmodule
